// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module   : icache
// Brief    : Direct-mapped, read-only, one-word-per-line instruction cache
//            with a single outstanding refill from the memory unit.
// Revision : 1.0
// ============================================================================
module icache #(
    parameter int INDEX_BIT = 6
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        clear,
    input  logic        inst_req,
    input  logic [31:0] pc,
    output logic        inst_ready,
    output logic [31:0] inst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data
);

    localparam int LINES = 1 << INDEX_BIT;
    localparam int TAG_W = 32 - INDEX_BIT - 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    state_t                 r_state;
    logic [LINES-1:0]       r_valid;
    logic [TAG_W-1:0]       r_tag  [LINES];
    logic [31:0]            r_data [LINES];
    logic [INDEX_BIT-1:0]   r_miss_idx;
    logic [TAG_W-1:0]       r_miss_tag;

    logic [INDEX_BIT-1:0]   w_idx;
    logic [TAG_W-1:0]       w_tag;
    logic                   w_hit;
    logic                   w_fill;
    logic                   w_unused;

    assign w_idx    = pc[INDEX_BIT+1:2];
    assign w_tag    = pc[31:INDEX_BIT+2];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // A refill that lands in the same cycle as a flush is still written:
    // the address was correct, only the response is dropped.
    assign w_fill   = rdy_in && (r_state == MISS) && mem_ready;
    assign w_unused = ^pc[1:0];

    always_ff @(posedge clk_in) begin
        if (!rst_in && w_fill) begin
            r_tag[r_miss_idx]  <= r_miss_tag;
            r_data[r_miss_idx] <= mem_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= IDLE;
            r_valid    <= '0;
            r_miss_idx <= '0;
            r_miss_tag <= '0;
            inst_ready <= 1'b0;
            inst       <= 32'h0;
            mem_req    <= 1'b0;
            mem_addr   <= 32'h0;
        end else begin
            if (w_fill) begin
                r_valid[r_miss_idx] <= 1'b1;
            end
            if (clear) begin
                r_state    <= IDLE;
                mem_req    <= 1'b0;
                inst_ready <= 1'b0;
            end else if (rdy_in) begin
                inst_ready <= 1'b0;
                case (r_state)
                    IDLE: begin
                        if (inst_req) begin
                            if (w_hit) begin
                                inst_ready <= 1'b1;
                                inst       <= r_data[w_idx];
                            end else begin
                                r_state    <= MISS;
                                mem_req    <= 1'b1;
                                mem_addr   <= {pc[31:2], 2'b00};
                                r_miss_idx <= w_idx;
                                r_miss_tag <= w_tag;
                            end
                        end
                    end
                    MISS: begin
                        if (mem_ready) begin
                            inst_ready <= 1'b1;
                            inst       <= mem_data;
                            mem_req    <= 1'b0;
                            r_state    <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
